// File: rtl/udc_sample_sched_pkg.sv
// Shared types and constants for the DC-link sample sequencer.
package udc_sample_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        QUIET = 2'd3
    } state_t;

    localparam int unsigned FRAME_BITS   = 16;
    localparam int unsigned LEAD_BITS    = 4;
    localparam int unsigned DATA_BITS    = FRAME_BITS - LEAD_BITS;
    localparam int unsigned FLT_EVAL_DLY = 3;

endpackage

// File: rtl/udc_sample_sched_fault_filter.sv
// Consecutive-sample filter turning a per-sample flag into a latched trip.
module udc_sample_sched_fault_filter #(
    parameter int unsigned FLT_CNT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic eval,
    input  logic flag,
    input  logic clr,
    output logic trip
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FLT_CNT);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             hit;

    // Saturating count of consecutive flagged evaluations; a threshold hit beats a clear.
    always_comb begin
        cnt_nxt = cnt;
        hit     = 1'b0;
        if (eval) begin
            if (flag) begin
                if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                hit = (cnt_nxt == CNT_MAX);
            end else begin
                cnt_nxt = '0;
            end
        end
        if (clr && !hit) begin
            cnt_nxt = '0;
        end
    end

    // Counter and trip latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            trip <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
            if (hit) begin
                trip <= 1'b1;
            end else if (clr) begin
                trip <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/udc_sample_sched.sv
// Periodic serial-ADC frame sequencer with OV/UV trip filtering.
module udc_sample_sched
    import udc_sample_sched_pkg::*;
#(
    parameter int unsigned CLK_DIV       = 4,
    parameter int unsigned SAMPLE_PERIOD = 5000,
    parameter int unsigned FLT_CNT       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_sdata,
    output logic [11:0] sample_data,
    output logic        data_valid,
    input  logic        dcov_in,
    input  logic        dcuv_in,
    input  logic        fault_clr,
    output logic        ov_trip,
    output logic        uv_trip,
    output logic        frame_err,
    output logic        overrun,
    output logic        busy
);

    localparam int unsigned TMR_W = $clog2(SAMPLE_PERIOD + 1);
    localparam int unsigned DIV_W = $clog2(CLK_DIV + 1);
    localparam int unsigned BIT_W = $clog2(FRAME_BITS);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [TMR_W-1:0]        timer;
    logic                    tick;
    state_t                  state;
    state_t                  state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic [DIV_W-1:0]        div_cnt_nxt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [BIT_W-1:0]        bit_cnt_nxt;
    logic                    high_ph;
    logic                    high_ph_nxt;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   shreg_nxt;
    logic                    cs_n_nxt;
    logic                    sclk_nxt;
    logic                    frame_done;
    logic                    frame_ok;
    logic [FLT_EVAL_DLY-1:0] eval_pipe;

    assign tick     = enable && (timer == '0);
    assign frame_ok = frame_done && (shreg_nxt[FRAME_BITS-1 -: LEAD_BITS] == '0);

    // Period timer: free-running while enabled, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if (!enable || timer == TMR_LAST) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    // Sequencer next-state, SCLK/CS pattern and serial capture.
    always_comb begin
        state_nxt   = state;
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        high_ph_nxt = high_ph;
        shreg_nxt   = shreg;
        cs_n_nxt    = 1'b1;
        sclk_nxt    = 1'b1;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                if (tick) begin
                    state_nxt   = SETUP;
                    div_cnt_nxt = '0;
                    cs_n_nxt    = 1'b0;
                end
            end
            SETUP: begin
                cs_n_nxt = 1'b0;
                if (div_cnt == DIV_LAST) begin
                    state_nxt   = SHIFT;
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    high_ph_nxt = 1'b0;
                    sclk_nxt    = 1'b0;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            SHIFT: begin
                cs_n_nxt = 1'b0;
                sclk_nxt = high_ph;
                if (high_ph && div_cnt == '0) begin
                    shreg_nxt = {shreg[FRAME_BITS-2:0], adc_sdata};
                end
                if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt = '0;
                    if (!high_ph) begin
                        high_ph_nxt = 1'b1;
                        sclk_nxt    = 1'b1;
                    end else if (bit_cnt == BIT_LAST) begin
                        state_nxt  = QUIET;
                        cs_n_nxt   = 1'b1;
                        frame_done = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt + BIT_W'(1);
                        high_ph_nxt = 1'b0;
                        sclk_nxt    = 1'b0;
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            QUIET: begin
                if (div_cnt == DIV_LAST) begin
                    state_nxt   = IDLE;
                    div_cnt_nxt = '0;
                end else begin
                    div_cnt_nxt = div_cnt + DIV_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            high_ph     <= 1'b0;
            shreg       <= '0;
            adc_cs_n    <= 1'b1;
            adc_sclk    <= 1'b1;
            busy        <= 1'b0;
            data_valid  <= 1'b0;
            frame_err   <= 1'b0;
            sample_data <= '0;
            overrun     <= 1'b0;
            eval_pipe   <= '0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            high_ph    <= high_ph_nxt;
            shreg      <= shreg_nxt;
            adc_cs_n   <= cs_n_nxt;
            adc_sclk   <= sclk_nxt;
            busy       <= (state_nxt != IDLE);
            data_valid <= frame_ok;
            frame_err  <= frame_done && !frame_ok;
            if (frame_ok) begin
                sample_data <= shreg_nxt[DATA_BITS-1:0];
            end
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            eval_pipe <= {eval_pipe[FLT_EVAL_DLY-2:0], data_valid};
        end
    end

    udc_sample_sched_fault_filter #(
        .FLT_CNT (FLT_CNT)
    ) u_ov_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .eval  (eval_pipe[FLT_EVAL_DLY-1]),
        .flag  (dcov_in),
        .clr   (fault_clr),
        .trip  (ov_trip)
    );

    udc_sample_sched_fault_filter #(
        .FLT_CNT (FLT_CNT)
    ) u_uv_filter (
        .clk   (clk),
        .rst_n (rst_n),
        .eval  (eval_pipe[FLT_EVAL_DLY-1]),
        .flag  (dcuv_in),
        .clr   (fault_clr),
        .trip  (uv_trip)
    );

endmodule
